mmap_arbiter: RTL and testbench

Two-master, one-slave arbiter for the 32-bit memory-mapped command bus. Master A is the host-side UART command decoder (`mmap_protocol`); master B is an on-chip requester such as the raycaster engine or a DMA. The block latches one-cycle command pulses from each master, grants the shared slave round-robin, issues exactly one command at a time, and routes the read data/ready back to the requester. An optional watchdog terminates transactions the slave never acknowledges.

---
 rtl/mmap_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mmap_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmap_arbiter.sv
// Two-master round-robin arbiter for the 32-bit memory-mapped command bus.
// Define MMAP_ARB_TIMEOUT_EN to add the WAIT-state watchdog.
module mmap_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  // master A
  input  logic        a_new_cmd,
  input  logic        a_write,
  input  logic [5:0]  a_cmd,
  input  logic [31:0] a_address,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_drdy,
  output logic        a_busy,
  // master B
  input  logic        b_new_cmd,
  input  logic        b_write,
  input  logic [5:0]  b_cmd,
  input  logic [31:0] b_address,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_drdy,
  output logic        b_busy,
  // shared slave
  output logic        s_new_cmd,
  output logic        s_write,
  output logic [5:0]  s_cmd,
  output logic [31:0] s_address,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_drdy,
  output logic        timeout_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned TW = 16;

  if (TIMEOUT < 1 || TIMEOUT > 65535 || $bits(TIMEOUT_DATA) != DW) begin : g_bad_param
    $error("mmap_arbiter: TIMEOUT must be 1..65535 and TIMEOUT_DATA 32 bits wide");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t        state;
  logic          a_pend;
  logic          b_pend;
  logic          a_req_write;
  logic [CW-1:0] a_req_cmd;
  logic [AW-1:0] a_req_address;
  logic [DW-1:0] a_req_wdata;
  logic          b_req_write;
  logic [CW-1:0] b_req_cmd;
  logic [AW-1:0] b_req_address;
  logic [DW-1:0] b_req_wdata;
  logic          gnt_b;
  logic          last_b;

  logic          grant_b_c;
  logic          done_c;
  logic [DW-1:0] done_data_c;

  assign a_busy = a_pend;
  assign b_busy = b_pend;

  // B wins when it is alone, or when both wait and A was served last
  assign grant_b_c = b_pend & (~a_pend | ~last_b);

`ifdef MMAP_ARB_TIMEOUT_EN
  logic [TW-1:0] wd_cnt;
  logic          wd_fire_c;

  // a slave answer in the final WAIT cycle still wins over the watchdog
  assign wd_fire_c   = (state == ST_WAIT) && !s_drdy && (wd_cnt == TW'(TIMEOUT));
  assign done_c      = ((state == ST_WAIT) && s_drdy) || wd_fire_c;
  assign done_data_c = s_drdy ? s_rdata : TIMEOUT_DATA;

  // watchdog counter: cleared in ISSUE, counts silent WAIT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire_c;
      if (state == ST_ISSUE) begin
        wd_cnt <= '0;
      end else if ((state == ST_WAIT) && !s_drdy && !wd_fire_c) begin
        wd_cnt <= wd_cnt + TW'(1);
      end
    end
  end
`else
  assign done_c      = (state == ST_WAIT) && s_drdy;
  assign done_data_c = s_rdata;
  assign timeout_err = 1'b0;
`endif

  // request capture, arbitration FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      a_pend        <= 1'b0;
      b_pend        <= 1'b0;
      a_req_write   <= 1'b0;
      a_req_cmd     <= '0;
      a_req_address <= '0;
      a_req_wdata   <= '0;
      b_req_write   <= 1'b0;
      b_req_cmd     <= '0;
      b_req_address <= '0;
      b_req_wdata   <= '0;
      gnt_b         <= 1'b0;
      last_b        <= 1'b1;
      s_new_cmd     <= 1'b0;
      s_write       <= 1'b0;
      s_cmd         <= '0;
      s_address     <= '0;
      s_wdata       <= '0;
      a_rdata       <= '0;
      a_drdy        <= 1'b0;
      b_rdata       <= '0;
      b_drdy        <= 1'b0;
    end else begin
      s_new_cmd <= 1'b0;
      a_drdy    <= 1'b0;
      b_drdy    <= 1'b0;

      // a pulse while busy is dropped so the captured request stays intact
      if (a_new_cmd && !a_pend) begin
        a_pend        <= 1'b1;
        a_req_write   <= a_write;
        a_req_cmd     <= a_cmd;
        a_req_address <= a_address;
        a_req_wdata   <= a_wdata;
      end
      if (b_new_cmd && !b_pend) begin
        b_pend        <= 1'b1;
        b_req_write   <= b_write;
        b_req_cmd     <= b_cmd;
        b_req_address <= b_address;
        b_req_wdata   <= b_wdata;
      end

      case (state)
        ST_IDLE: begin
          if (a_pend || b_pend) begin
            gnt_b     <= grant_b_c;
            last_b    <= grant_b_c;
            s_new_cmd <= 1'b1;
            s_write   <= grant_b_c ? b_req_write   : a_req_write;
            s_cmd     <= grant_b_c ? b_req_cmd     : a_req_cmd;
            s_address <= grant_b_c ? b_req_address : a_req_address;
            s_wdata   <= grant_b_c ? b_req_wdata   : a_req_wdata;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_c) begin
            if (gnt_b) begin
              b_rdata <= done_data_c;
              b_drdy  <= 1'b1;
              b_pend  <= 1'b0;
            end else begin
              a_rdata <= done_data_c;
              a_drdy  <= 1'b1;
              a_pend  <= 1'b0;
            end
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmap_arbiter.sv
// Randomized bench for mmap_arbiter against a transaction-level round-robin model.
// Build with MMAP_ARB_TIMEOUT_EN defined to exercise the watchdog as well.
module tb_mmap_arbiter;

  localparam int unsigned TO      = 8;
  localparam logic [31:0] TO_DATA = 32'hDEADBEEF;
`ifdef MMAP_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        a_new_cmd, a_write, a_drdy, a_busy;
  logic [5:0]  a_cmd;
  logic [31:0] a_address, a_wdata, a_rdata;
  logic        b_new_cmd, b_write, b_drdy, b_busy;
  logic [5:0]  b_cmd;
  logic [31:0] b_address, b_wdata, b_rdata;
  logic        s_new_cmd, s_write, s_drdy, timeout_err;
  logic [5:0]  s_cmd;
  logic [31:0] s_address, s_wdata, s_rdata;

  mmap_arbiter #(.TIMEOUT(TO), .TIMEOUT_DATA(TO_DATA)) dut (
    .clk(clk), .rst(rst),
    .a_new_cmd(a_new_cmd), .a_write(a_write), .a_cmd(a_cmd), .a_address(a_address),
    .a_wdata(a_wdata), .a_rdata(a_rdata), .a_drdy(a_drdy), .a_busy(a_busy),
    .b_new_cmd(b_new_cmd), .b_write(b_write), .b_cmd(b_cmd), .b_address(b_address),
    .b_wdata(b_wdata), .b_rdata(b_rdata), .b_drdy(b_drdy), .b_busy(b_busy),
    .s_new_cmd(s_new_cmd), .s_write(s_write), .s_cmd(s_cmd), .s_address(s_address),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_drdy(s_drdy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [5:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (edge-level view of the bus, not of the FSM)
  bit          m_pend[2];
  req_t        m_req[2];
  logic [31:0] m_rdata[2];
  bit          m_last_b;
  bit          in_svc;
  int          svc;
  int          iss_cyc;
  int          cyc;
  int          acc_cyc[2];
  int          lat[2];
  int          idle_cnt;
  int          drdy_cnt[2];
  int          acc_cnt[2];
  int          to_cnt;
  int          grant_log[$];
  logic [31:0] last_issue_addr;
  // slave behaviour knobs
  int          slave_delay;
  logic [31:0] resp_data;
  bit          resp_fixed;
  bit          silent;
  bit          spur_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a_rdata"}, a_rdata, 0);
    check_eq({tag, "_a_drdy"}, 32'(a_drdy), 0);
    check_eq({tag, "_a_busy"}, 32'(a_busy), 0);
    check_eq({tag, "_b_rdata"}, b_rdata, 0);
    check_eq({tag, "_b_drdy"}, 32'(b_drdy), 0);
    check_eq({tag, "_b_busy"}, 32'(b_busy), 0);
    check_eq({tag, "_s_new_cmd"}, 32'(s_new_cmd), 0);
    check_eq({tag, "_s_write"}, 32'(s_write), 0);
    check_eq({tag, "_s_cmd"}, 32'(s_cmd), 0);
    check_eq({tag, "_s_address"}, s_address, 0);
    check_eq({tag, "_s_wdata"}, s_wdata, 0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.wr    = 1'($urandom_range(0, 1));
    r.cmd   = 6'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic drive_a(input req_t r);
    a_new_cmd = 1'b1; a_write = r.wr; a_cmd = r.cmd; a_address = r.addr; a_wdata = r.wdata;
  endtask

  task automatic drive_b(input req_t r);
    b_new_cmd = 1'b1; b_write = r.wr; b_cmd = r.cmd; b_address = r.addr; b_wdata = r.wdata;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 1'b0; m_rdata[m] = '0; drdy_cnt[m] = 0; acc_cnt[m] = 0; lat[m] = 0;
    end
    m_last_b = 1'b1; in_svc = 1'b0; idle_cnt = 0; to_cnt = 0;
    grant_log.delete();
  endtask

  // advance one edge, update the model with what the inputs asked for, compare, set next inputs
  task automatic step();
    bit old_pend[2];
    bit old_svc;
    bit acc[2];
    bit exp_drdy[2];
    bit to;
    int comp;
    int g;
    logic [31:0] cdata;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    old_pend = m_pend;
    old_svc  = in_svc;
    acc[0] = a_new_cmd && !old_pend[0];
    acc[1] = b_new_cmd && !old_pend[1];
    comp = -1; to = 1'b0; cdata = '0;
    exp_drdy[0] = 1'b0; exp_drdy[1] = 1'b0;
    if (in_svc && cyc >= iss_cyc + 2) begin
      if (s_drdy) begin
        comp = svc; cdata = s_rdata;
      end else if (TO_EN && cyc == iss_cyc + 2 + int'(TO)) begin
        comp = svc; cdata = TO_DATA; to = 1'b1;
      end
    end
    if (comp >= 0) begin
      exp_drdy[comp] = 1'b1; m_rdata[comp] = cdata; m_pend[comp] = 1'b0; in_svc = 1'b0;
      lat[comp] = cyc - acc_cyc[comp]; drdy_cnt[comp]++;
      if (to) to_cnt++;
    end
    if (acc[0]) begin
      m_pend[0] = 1'b1; m_req[0] = '{a_write, a_cmd, a_address, a_wdata}; acc_cyc[0] = cyc; acc_cnt[0]++;
    end
    if (acc[1]) begin
      m_pend[1] = 1'b1; m_req[1] = '{b_write, b_cmd, b_address, b_wdata}; acc_cyc[1] = cyc; acc_cnt[1]++;
    end
    if (s_new_cmd) begin
      check_eq("issue_needs_pending", 32'(old_pend[0] | old_pend[1]), 1);
      check_eq("issue_overlap", 32'(old_svc), 0);
      if (old_pend[0] && old_pend[1]) g = m_last_b ? 0 : 1;
      else g = old_pend[0] ? 0 : 1;
      in_svc = 1'b1; svc = g; iss_cyc = cyc; m_last_b = (g == 1);
      grant_log.push_back(g); last_issue_addr = s_address;
      if (!resp_fixed) begin
        slave_delay = $urandom_range(0, 4);
        resp_data   = $urandom;
      end
    end

    check_eq("a_busy", 32'(a_busy), 32'(m_pend[0]));
    check_eq("b_busy", 32'(b_busy), 32'(m_pend[1]));
    check_eq("a_drdy", 32'(a_drdy), 32'(exp_drdy[0]));
    check_eq("b_drdy", 32'(b_drdy), 32'(exp_drdy[1]));
    check_eq("a_rdata", a_rdata, m_rdata[0]);
    check_eq("b_rdata", b_rdata, m_rdata[1]);
    check_eq("timeout_err", 32'(timeout_err), 32'(to));
    if (in_svc) begin
      check_eq("s_write", 32'(s_write), 32'(m_req[svc].wr));
      check_eq("s_cmd", 32'(s_cmd), 32'(m_req[svc].cmd));
      check_eq("s_address", s_address, m_req[svc].addr);
      check_eq("s_wdata", s_wdata, m_req[svc].wdata);
    end
    if (!in_svc && (m_pend[0] || m_pend[1])) idle_cnt++;
    else idle_cnt = 0;
    if (idle_cnt > 2) check_eq("stall_cycles", 32'(idle_cnt), 0);

    a_new_cmd = 1'b0;
    b_new_cmd = 1'b0;
    if (in_svc && !silent && cyc + 1 >= iss_cyc + 2 + slave_delay) begin
      s_drdy = 1'b1; s_rdata = resp_data;
    end else if (spur_en && !(in_svc && cyc + 1 >= iss_cyc + 2) && $urandom_range(0, 3) == 0) begin
      s_drdy = 1'b1; s_rdata = $urandom;
    end else begin
      s_drdy = 1'b0; s_rdata = $urandom;
    end
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while ((m_pend[0] || m_pend[1] || in_svc) && k < max_cyc) begin
      step();
      k++;
    end
    check_eq("drain_done", 32'(m_pend[0] | m_pend[1] | in_svc), 0);
  endtask

  // asynchronous reset between edges; outputs must clear before the next edge
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_all_zero(tag);
    a_new_cmd = 1'b0; b_new_cmd = 1'b0; s_drdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    req_t r;
    rst = 1'b1; cyc = 0;
    a_new_cmd = 0; a_write = 0; a_cmd = 0; a_address = 0; a_wdata = 0;
    b_new_cmd = 0; b_write = 0; b_cmd = 0; b_address = 0; b_wdata = 0;
    s_drdy = 0; s_rdata = 0;
    spur_en = 0; silent = 0; resp_fixed = 0; slave_delay = 0; resp_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // A read alone, slave answers in the first WAIT cycle
    resp_fixed = 1; slave_delay = 0; resp_data = 32'hAAAAAAAA;
    drive_a('{1'b0, 6'h01, 32'h0000_0100, 32'h0});
    step();
    drain(20);
    check_eq("t1_latency", 32'(lat[0]), 3);
    check_eq("t1_issues", 32'(grant_log.size()), 1);
    check_eq("t1_a_rdata", a_rdata, 32'hAAAAAAAA);
    check_eq("t1_b_drdy_cnt", 32'(drdy_cnt[1]), 0);
    resp_fixed = 0;

    // simultaneous A write and B read after reset: A first
    do_reset("t2_reset");
    drive_a('{1'b1, 6'h02, 32'h0000_0001, 32'h0000_007F});
    drive_b('{1'b0, 6'h03, 32'h0000_0010, 32'h0});
    step();
    drain(40);
    check_eq("t2_issues", 32'(grant_log.size()), 2);
    check_eq("t2_first", 32'(grant_log[0]), 0);
    check_eq("t2_second", 32'(grant_log[1]), 1);
    check_eq("t2_a_drdy_cnt", 32'(drdy_cnt[0]), 1);
    check_eq("t2_b_drdy_cnt", 32'(drdy_cnt[1]), 1);

    // both masters keep requesting: grants alternate A,B,A,B,A,B
    do_reset("t3_reset");
    for (int k = 0; k < 200 && grant_log.size() < 6; k++) begin
      if (!m_pend[0]) drive_a(rand_req());
      if (!m_pend[1]) drive_b(rand_req());
      step();
    end
    drain(40);
    for (int i = 0; i < 6; i++) check_eq($sformatf("t3_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // second A pulse while busy is ignored
    do_reset("t4_reset");
    drive_a('{1'b0, 6'h04, 32'h0000_0040, 32'h0});
    step();
    drive_a('{1'b1, 6'h05, 32'h0000_0080, 32'h1234_5678});
    step();
    drain(20);
    check_eq("t4_issues", 32'(grant_log.size()), 1);
    check_eq("t4_addr", last_issue_addr, 32'h0000_0040);

`ifdef MMAP_ARB_TIMEOUT_EN
    // silent slave: watchdog completes A, then B is served normally
    do_reset("t5_reset");
    silent = 1;
    drive_a('{1'b0, 6'h06, 32'h0000_0200, 32'h0});
    step();
    for (int k = 0; k < 40 && drdy_cnt[0] == 0; k++) step();
    check_eq("t5_to_cnt", 32'(to_cnt), 1);
    check_eq("t5_latency", 32'(lat[0]), 32'(TO + 3));
    check_eq("t5_a_rdata", a_rdata, 32'hDEADBEEF);
    silent = 0;
    drive_b('{1'b0, 6'h07, 32'h0000_0300, 32'h0});
    step();
    drain(20);
    check_eq("t5_b_drdy_cnt", 32'(drdy_cnt[1]), 1);
    check_eq("t5_to_cnt_after", 32'(to_cnt), 1);
`endif

    // reset while WAITing: everything clears, no completion, then normal service
    do_reset("t6_pre");
    silent = 1;
    drive_a('{1'b0, 6'h08, 32'h0000_0400, 32'h0});
    repeat (4) step();
    check_eq("t6_in_wait", 32'(in_svc), 1);
    do_reset("t6_mid_wait");
    silent = 0;
    repeat (4) step();
    check_eq("t6_no_drdy", 32'(drdy_cnt[0] + drdy_cnt[1]), 0);
    drive_a('{1'b0, 6'h09, 32'h0000_0500, 32'h0});
    step();
    drain(20);
    check_eq("t6_a_drdy_cnt", 32'(drdy_cnt[0]), 1);

    // random traffic with stray s_drdy pulses outside WAIT
    do_reset("t7_reset");
    spur_en = 1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) drive_a(rand_req());
      if ($urandom_range(0, 2) == 0) drive_b(rand_req());
      step();
    end
    spur_en = 0;
    drain(40);
    check_eq("t7_a_complete", 32'(drdy_cnt[0]), 32'(acc_cnt[0]));
    check_eq("t7_b_complete", 32'(drdy_cnt[1]), 32'(acc_cnt[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
